// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC muxed-bus master and the slave-side bench.
package fsmc_pkg;
  localparam int AD_W   = 18;
  localparam int DATA_W = 16;
  localparam int CS_MSB = 17;
  localparam int CS_LSB = 15;

  localparam int DEF_ADDSET  = 4;
  localparam int DEF_ADDHLD  = 6;
  localparam int DEF_DATAST  = 8;
  localparam int DEF_DHOLD   = 4;
  localparam int DEF_BUSTURN = 4;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AHOLD,
    S_WDATA,
    S_WHOLD,
    S_RDATA,
    S_TURN
  } fsmc_master_state_t;
endpackage

// File: rtl/fsmc_master_if.sv
// Request/response handshake between an internal requester and fsmc_master.
interface fsmc_master_if;
  import fsmc_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AD_W-1:0]   req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/fsmc_master.sv
// FSMC muxed-mode initiator: turns one accepted request into a timed
// NADV/NWE/NOE bus cycle on the shared 18-bit AD bus.
module fsmc_master
  import fsmc_pkg::*;
#(
  parameter int ADDSET  = DEF_ADDSET,
  parameter int ADDHLD  = DEF_ADDHLD,
  parameter int DATAST  = DEF_DATAST,
  parameter int DHOLD   = DEF_DHOLD,
  parameter int BUSTURN = DEF_BUSTURN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  fsmc_master_if.master  req,
  inout  wire [AD_W-1:0] AD,
  output logic           NADV,
  output logic           NWE,
  output logic           NOE
);

  fsmc_master_state_t state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [AD_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              write_q, write_n;
  logic [AD_W-1:0]   ad_out, ad_out_n;
  logic              ad_oe_hi, ad_oe_lo, oe_hi_n, oe_lo_n;
  logic              accept, last;

  function automatic logic [CNT_W-1:0] phase_len(input fsmc_master_state_t s);
    case (s)
      S_ADDR:  return CNT_W'(ADDSET - 1);
      S_AHOLD: return CNT_W'(ADDHLD - 1);
      S_WDATA: return CNT_W'(DATAST - 1);
      S_WHOLD: return CNT_W'(DHOLD - 1);
      S_RDATA: return CNT_W'(DATAST - 1);
      S_TURN:  return CNT_W'(BUSTURN - 1);
      default: return '0;
    endcase
  endfunction

  assign accept = (state == S_IDLE) && req.req_valid && req.req_ready;
  assign last   = (cnt == '0);

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    write_n = write_q;
    unique case (state)
      S_IDLE: if (accept) begin
        state_n = S_ADDR;
        addr_n  = req.req_addr;
        wdata_n = req.req_wdata;
        write_n = req.req_write;
      end
      S_ADDR:  if (last) state_n = S_AHOLD;
      S_AHOLD: if (last) state_n = write_q ? S_WDATA : S_RDATA;
      S_WDATA: if (last) state_n = S_WHOLD;
      S_WHOLD: if (last) state_n = S_IDLE;
      S_RDATA: if (last) state_n = S_TURN;
      S_TURN:  if (last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (state_n != state)      cnt_n = phase_len(state_n);
    else if (state != S_IDLE)  cnt_n = cnt - 1'b1;
    else                       cnt_n = cnt;

    // Bus drive is decoded from the next state so pins change on the same edge as the FSM.
    ad_out_n = '0;
    oe_hi_n  = 1'b0;
    oe_lo_n  = 1'b0;
    case (state_n)
      S_ADDR, S_AHOLD: begin
        ad_out_n = addr_n;
        oe_hi_n  = 1'b1;
        oe_lo_n  = 1'b1;
      end
      S_WDATA, S_WHOLD: begin
        ad_out_n = {addr_n[AD_W-1:DATA_W], wdata_n};
        oe_hi_n  = 1'b1;
        oe_lo_n  = 1'b1;
      end
      S_RDATA: begin
        ad_out_n = {addr_n[AD_W-1:DATA_W], {DATA_W{1'b0}}};
        oe_hi_n  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      ad_out        <= '0;
      ad_oe_hi      <= 1'b0;
      ad_oe_lo      <= 1'b0;
      NADV          <= 1'b1;
      NWE           <= 1'b1;
      NOE           <= 1'b1;
      req.req_ready <= 1'b0;
      req.busy      <= 1'b0;
      req.rsp_valid <= 1'b0;
      req.rsp_rdata <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      write_q       <= write_n;
      ad_out        <= ad_out_n;
      ad_oe_hi      <= oe_hi_n;
      ad_oe_lo      <= oe_lo_n;
      NADV          <= (state_n != S_ADDR);
      NWE           <= (state_n != S_WDATA);
      NOE           <= (state_n != S_RDATA);
      req.req_ready <= (state_n == S_IDLE);
      req.busy      <= (state_n != S_IDLE);
      req.rsp_valid <= 1'b0;
      if (state == S_RDATA && last) begin
        req.rsp_valid <= 1'b1;
        req.rsp_rdata <= AD[DATA_W-1:0];
      end
    end
  end

  assign AD[AD_W-1:DATA_W] = ad_oe_hi ? ad_out[AD_W-1:DATA_W] : 'z;
  assign AD[DATA_W-1:0]    = ad_oe_lo ? ad_out[DATA_W-1:0]    : 'z;

endmodule

// File: tb/tb_fsmc_master.sv
// Scoreboard bench for fsmc_master: randomized requests, a behavioural bus
// slave on AD, and a per-cycle timing model derived from the phase lengths.
module tb_fsmc_master;
  import fsmc_pkg::*;

  localparam int A = DEF_ADDSET;
  localparam int H = DEF_ADDHLD;
  localparam int D = DEF_DATAST;
  localparam int X = DEF_DHOLD;
  localparam int T = DEF_BUSTURN;

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fsmc_master_if bus1();
  fsmc_master_if bus2();
  wire [AD_W-1:0] AD1, AD2;
  logic NADV1, NWE1, NOE1, NADV2, NWE2, NOE2;

  fsmc_master #(.ADDSET(A), .ADDHLD(H), .DATAST(D), .DHOLD(X), .BUSTURN(T), .CNT_W(DEF_CNT_W)) dut1 (
    .clk(clk), .reset(reset), .req(bus1), .AD(AD1), .NADV(NADV1), .NWE(NWE1), .NOE(NOE1));

  fsmc_master #(.ADDSET(1), .ADDHLD(1), .DATAST(1), .DHOLD(1), .BUSTURN(1), .CNT_W(DEF_CNT_W)) dut2 (
    .clk(clk), .reset(reset), .req(bus2), .AD(AD2), .NADV(NADV2), .NWE(NWE2), .NOE(NOE2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int edges_since_rst = 0;
  bit mon_en = 1'b0;

  txn_t        sb_q[$];
  logic [33:0] wr_q[$];
  logic [15:0] mdl_mem[logic [17:0]];
  logic [15:0] slv_mem[logic [17:0]];
  logic [17:0] slv_addr = '0;
  logic [15:0] slv_data = '0;
  logic [33:0] wr_exp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference memory: region 5 is a register slave that always reads 0xBEEF.
  function automatic logic [15:0] mdl_rd(input logic [17:0] a);
    if (a[CS_MSB:CS_LSB] == 3'b101) return 16'hBEEF;
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return a[15:0] ^ 16'h5AA5;
  endfunction

  function automatic logic [15:0] slv_rd(input logic [17:0] a);
    if (a[CS_MSB:CS_LSB] == 3'b101) return 16'hBEEF;
    if (slv_mem.exists(a)) return slv_mem[a];
    return a[15:0] ^ 16'h5AA5;
  endfunction

  // Bus slave behaviour on AD1
  assign AD1[15:0] = !NOE1 ? slv_data : 'z;
  assign AD2[15:0] = !NOE2 ? 16'h5A3C : 'z;

  always @(posedge NADV1) if (reset) slv_addr = AD1;
  always @(negedge NOE1)  if (reset) slv_data = slv_rd(slv_addr);
  always @(posedge NWE1) if (reset) begin
    slv_mem[slv_addr] = AD1[15:0];
    if (wr_q.size() == 0) begin
      total++; bad++;
      $display("FAIL wr_unexpected: got %0h want none", {slv_addr, AD1[15:0]});
    end else begin
      wr_exp = wr_q.pop_front();
      chk("wr_bus", {30'd0, slv_addr, AD1[15:0]}, {30'd0, wr_exp});
    end
  end

  always @(posedge clk) cyc++;
  always @(posedge clk or negedge reset)
    if (!reset) edges_since_rst = 0;
    else if (edges_since_rst < 1000) edges_since_rst++;

  // Monitor: per-cycle expectations from phase boundaries of the active transaction
  txn_t        cur;
  bit          active = 1'b0;
  int          k = 0;
  int          end_k;
  logic [15:0] last_rd = '0;
  bit          lo;
  always @(negedge clk) begin
    if (!reset) last_rd = '0;
    if (!mon_en || !reset) begin
      active = 1'b0;
    end else if (active) begin
      k++;
      lo    = (k >= A + H + 1) && (k <= A + H + D);
      end_k = A + H + D + (cur.wr ? X : T);
      chk("ctrl", {58'd0, NADV1, NWE1, NOE1, bus1.busy, bus1.req_ready, bus1.rsp_valid},
          {58'd0, (k > A), !(cur.wr && lo), !(!cur.wr && lo), 1'b1, 1'b0,
           (!cur.wr && k == A + H + D + 1)});
      if (k <= A + H)    chk("ad_addr", {46'd0, AD1}, {46'd0, cur.addr});
      else if (cur.wr)   chk("ad_wdata", {46'd0, AD1}, {46'd0, cur.addr[17:16], cur.wdata});
      else if (lo)       chk("ad_hi", {62'd0, AD1[17:16]}, {62'd0, cur.addr[17:16]});
      if (!cur.wr && k == A + H + D + 1) begin
        chk("rdata", {48'd0, bus1.rsp_rdata}, {48'd0, cur.rdata});
        last_rd = cur.rdata;
      end
      if (k == end_k) active = 1'b0;
    end else begin
      chk("idle", {41'd0, NADV1, NWE1, NOE1, bus1.busy, bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata},
          {41'd0, 3'b111, 1'b0, (edges_since_rst > 0), 1'b0, last_rd});
      if (bus1.req_valid && bus1.req_ready) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: got accept want none");
        end else begin
          cur    = sb_q.pop_front();
          active = 1'b1;
          k      = 0;
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [17:0] a, input logic [15:0] d,
                       input bit keep, output int acc);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = d;
    t.rdata = wr ? 16'h0 : mdl_rd(a);
    if (wr) begin
      mdl_mem[a] = d;
      wr_q.push_back({a, d});
    end
    sb_q.push_back(t);
    @(posedge clk); #1;
    bus1.req_valid = 1'b1;
    bus1.req_write = wr;
    bus1.req_addr  = a;
    bus1.req_wdata = d;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus1.req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no req_ready want req_ready within 200 cycles");
    end
    @(posedge clk); #1;
    // Scramble fields mid-transaction; they must not affect the bus cycle.
    bus1.req_write = ~wr;
    bus1.req_addr  = ~a;
    bus1.req_wdata = ~d;
    if (!keep) bus1.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus1.busy && bus1.req_ready && !bus1.req_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy want idle within 200 cycles");
    end
  endtask

  task automatic run2(input logic wr, output int bcyc, output int rk, output logic [15:0] rd);
    bit got = 1'b0;
    bcyc = 0; rk = 0; rd = '0;
    @(posedge clk); #1;
    bus2.req_valid = 1'b1;
    bus2.req_write = wr;
    bus2.req_addr  = 18'h2_0003;
    bus2.req_wdata = 16'h0F0F;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus2.req_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL p1_accept_timeout: got no req_ready want req_ready");
    end
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (bus2.rsp_valid) begin rk = j; rd = bus2.rsp_rdata; end
      if (bus2.busy) bcyc++;
      else break;
    end
  endtask

  int acc1, acc2, bc, rk;
  logic [15:0] rd;
  bit found;

  initial begin
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    mdl_mem[18'h1_0010] = 16'h1234;
    slv_mem[18'h1_0010] = 16'h1234;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {41'd0, NADV1, NWE1, NOE1, bus1.req_ready, bus1.rsp_valid, bus1.busy, bus1.rsp_rdata},
        {41'd0, 3'b111, 3'b000, 16'h0000});
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    issue(1'b1, 18'h2_8005, 16'hA5C3, 1'b0, acc1);
    issue(1'b0, 18'h1_0010, 16'h0000, 1'b0, acc1);

    // Back-to-back with req_valid held
    issue(1'b1, 18'h0_0101, 16'h0001, 1'b1, acc1);
    issue(1'b0, 18'h0_0101, 16'h0000, 1'b0, acc2);
    chk("b2b_gap", acc2 - acc1, A + H + D + X + 1);

    // Region 5 loopback: write lands at region 5, reads return the register value
    issue(1'b1, 18'h2_8100, 16'h5555, 1'b0, acc1);
    issue(1'b0, 18'h2_8100, 16'h0000, 1'b0, acc1);

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)),
            {3'($urandom_range(0, 7)), 12'h000, 3'($urandom_range(0, 7))},
            16'($urandom),
            (i != 39) && ($urandom_range(0, 3) == 0),
            acc1);
    end
    wait_idle();

    // Reset in the middle of RDATA
    issue(1'b0, 18'h0_4004, 16'h0000, 1'b0, acc1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!NOE1) begin found = 1'b1; break; end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL noe_timeout: got NOE high want NOE low");
    end
    repeat (3) @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_async", {58'd0, NADV1, NWE1, NOE1, bus1.busy, bus1.req_ready, bus1.rsp_valid},
        {58'd0, 6'b111000});
    repeat (3) begin
      @(negedge clk);
      chk("rst_norsp", {63'd0, bus1.rsp_valid}, 64'd0);
    end
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_rst", {63'd0, bus1.req_ready}, 64'd1);
    issue(1'b1, 18'h3_0707, 16'hC0DE, 1'b0, acc1);
    issue(1'b0, 18'h3_0707, 16'h0000, 1'b0, acc1);
    wait_idle();

    // Minimal timing instance
    run2(1'b1, bc, rk, rd);
    chk("p1_wr_busy", bc, 4);
    run2(1'b0, bc, rk, rd);
    chk("p1_rd_busy", bc, 4);
    chk("p1_rsp_k", rk, 4);
    chk("p1_rdata", {48'd0, rd}, {48'd0, 16'h5A3C});

    repeat (5) @(negedge clk);
    chk("sb_left", sb_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fsmc_master.md
Name: fsmc_master

Overview:
- FSMC initiator that drives the multiplexed 18-bit AD bus with NADV/NWE/NOE, emulating the STM32 FSMC muxed-mode master.
- Used as the on-FPGA stimulus source for loopback and bring-up of the FSMC slave path.
- Used to bridge internal requests onto an external FSMC-style peripheral bus.
- Converts a valid/ready request (address, write data, direction) into one timed bus cycle and returns read data with a single-cycle response pulse.

Parameters:
- ADDSET, 4: cycles NADV held low with the address driven (≥1).
- ADDHLD, 6: cycles the address is held after NADV rises (≥1).
- DATAST, 8: cycles NWE or NOE is held low (≥1).
- DHOLD, 4: cycles write data is held after NWE rises (≥1).
- BUSTURN, 4: cycles AD[15:0] stays released after NOE rises before the next request is accepted (≥1).
- CNT_W, 8: phase counter width; every timing parameter must be ≤ 2^CNT_W.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high together with req_valid
- req_write  input  1  1 = write, 0 = read
- req_addr  input  18  bus address; [17:15] selects the slave region
- req_wdata  input  16  write data
- rsp_valid  output  1  one-cycle pulse: read data valid
- rsp_rdata  output  16  read data, held until the next read completes
- busy  output  1  high in every state except IDLE
- AD  inout  18  multiplexed address/data bus
- NADV  output  1  address valid, active low
- NWE  output  1  write strobe, active low
- NOE  output  1  read strobe, active low

Behaviour:
- All outputs are registered.
- Reset values: NADV=NWE=NOE=1; AD fully released (Z); req_ready=0 during reset, 1 on the first cycle after release; rsp_valid=0; rsp_rdata=0; busy=0.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- States: IDLE, ADDR, AHOLD, WDATA, WHOLD, RDATA, TURN.
- Each state loads its counter with (param-1) on entry and exits when the counter reaches 0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/wdata/write and go to ADDR.
  - req_ready drops on the next cycle; at most one request is outstanding.
- ADDR: AD=addr (all 18 bits driven), NADV=0, ADDSET cycles.
- AHOLD: NADV=1, AD=addr, ADDHLD cycles. Then go to WDATA if write, else RDATA.
- WDATA:
  - AD[17:16]=addr[17:16], AD[15:0]=wdata, NWE=0, DATAST cycles.
  - The slave samples on the NWE rising edge, so data must be stable throughout this state.
- WHOLD: NWE=1, data still driven, DHOLD cycles; then IDLE with AD released.
- RDATA:
  - AD[17:16]=addr[17:16]; AD[15:0] released from the first RDATA cycle; NOE=0 for DATAST cycles.
  - On the final RDATA cycle, capture rsp_rdata=AD[15:0].
  - rsp_valid pulses high on the next cycle, coincident with NOE=1.
- TURN: NOE=1, AD fully released, BUSTURN cycles; then IDLE.
- Cycle counts:
  - Write: request accept to return to IDLE = ADDSET+ADDHLD+DATAST+DHOLD cycles.
  - Read: request accept to return to IDLE = ADDSET+ADDHLD+DATAST+BUSTURN cycles.
  - Read latency: request accept to rsp_valid = ADDSET+ADDHLD+DATAST+1.
- Strobe rule: NWE and NOE are never low simultaneously, and never low while NADV is low.
- Drive rule: AD[15:0] is never driven by this block while NOE=0.
- Reset mid-transaction: immediately return to IDLE, strobes high, AD released, no rsp_valid, request discarded.
- req_valid held high continuously produces back-to-back transactions separated only by the single IDLE cycle.
- req_* changing during a transaction has no effect.

Decomposition:
- Shared package fsmc_pkg:
  - AD_W=18, DATA_W=16, CS_MSB=17, CS_LSB=15.
  - State enum fsmc_master_state_t.
  - Default timing constants, shared with the slave-side bench.
- No sub-module: one FSM plus one down-counter belongs in a single module.
- Tristate is expressed as ad_oe_hi (bits 17:16) and ad_oe_lo (bits 15:0) with an output register.

Test Plan:
1. Write addr=0x2_8005, wdata=0xA5C3 with defaults:
   - NADV low 4 cycles with AD=0x28005.
   - NWE low cycles 11–18 with AD[15:0]=0xA5C3.
   - busy high 22 cycles, then req_ready=1.
2. Read addr=0x1_0010 with a bench model driving AD[15:0]=0x1234 while NOE=0:
   - rsp_valid pulses at cycle 19 after accept with rsp_rdata=0x1234.
   - AD[15:0] is Z throughout NOE low.
3. req_valid held with write 0x0001 then read:
   - Exactly one IDLE cycle between transactions.
   - No overlap of NADV, NWE and NOE lows.
   - The second request is accepted only after the first completes.
4. Reset asserted in the middle of the RDATA phase:
   - The next clock edge is not needed: NOE=1 and AD=Z immediately.
   - rsp_valid never pulses.
   - After release, req_ready=1 and a fresh write completes normally.
5. Parameters ADDSET=ADDHLD=DATAST=DHOLD=BUSTURN=1:
   - Write completes in 4 cycles; read completes in 4 cycles with rsp_valid at cycle 4.
6. Loopback against the FSMC slave with its cs_state=1 and module_out=0xBEEF:
   - Write 0x5555 to region 3'b101: the slave's module_in=0x5555 and cs_addr_latch=3'b101.
   - A subsequent read returns 0xBEEF.
